// File: rtl/uart_si_pkg.sv
// ---------------------------------------------------------------------------
// uart_si_pkg
// Shared definitions for the UART simple-interface sequencer:
//   - register addresses on the UART simple interface (addr/re/we/wd/rd)
//   - bit positions inside the UART control register
//   - sequencer state encoding
//   - helper that builds the control-register word written at init
// ---------------------------------------------------------------------------
package uart_si_pkg;

    // Register map of the UART simple interface
    localparam logic [3:0] UART_CR    = 4'h0;
    localparam logic [3:0] UART_TX_RX = 4'h4;
    localparam logic [3:0] UART_DR    = 4'h8;

    // Control register bit positions
    localparam int CR_TX_EN     = 0;
    localparam int CR_RX_EN     = 1;
    localparam int CR_TX_FULL   = 2;
    localparam int CR_RX_FULL   = 3;
    localparam int CR_TX_LVL_LO = 4;
    localparam int CR_TX_LVL_HI = 5;
    localparam int CR_RX_LVL_LO = 6;
    localparam int CR_RX_LVL_HI = 7;

    // Sequencer states
    typedef enum logic [2:0] {
        S_RST     = 3'd0,
        S_INIT_DR = 3'd1,
        S_INIT_CR = 3'd2,
        S_IDLE    = 3'd3,
        S_POLL    = 3'd4,
        S_WR_TX   = 3'd5,
        S_RD_RX   = 3'd6,
        S_RX_DONE = 3'd7
    } seq_state_t;

    // Control word: both FIFO level fields, status bits written as zero,
    // TX and RX enabled.
    function automatic logic [31:0] cr_word(input logic [1:0] rx_lvl,
                                            input logic [1:0] tx_lvl);
        logic [31:0] w;
        w = 32'h0000_0000;
        w[CR_RX_LVL_HI:CR_RX_LVL_LO] = rx_lvl;
        w[CR_TX_LVL_HI:CR_TX_LVL_LO] = tx_lvl;
        w[CR_TX_EN] = 1'b1;
        w[CR_RX_EN] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/uart_si_seq.sv
// ---------------------------------------------------------------------------
// uart_si_seq
// Owns the UART simple interface and presents a byte stream to the host.
// After reset it writes the divider and control registers, then serves host
// TX bytes (polling tx_full before each write) and host RX read requests,
// alternating between them when both are pending.
//
// Ports:
//   clk, rstn            clock; synchronous active-high reset
//   tx_valid/tx_data     host TX byte (held while tx_valid)
//   tx_ready             one-cycle pulse when the byte is written to the UART
//   rx_req               host RX request level, held until rx_valid
//   rx_valid/rx_data     one-cycle pulse with the byte read from the RX FIFO
//   cfg_reload/cfg_div   request a new divider and a full re-init
//   init_done            high once the UART is programmed
//   addr/re/we/wd/rd     UART simple interface
//
// All SI and handshake outputs are registered copies of the decode of the
// next state, so each output equals the decode of the current state with no
// combinational path from inputs.
// ---------------------------------------------------------------------------
module uart_si_seq
    import uart_si_pkg::*;
#(
    parameter logic [15:0] DIV    = 16'd434,
    parameter logic [1:0]  TX_LVL = 2'b00,
    parameter logic [1:0]  RX_LVL = 2'b00
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    input  logic        rx_req,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    input  logic        cfg_reload,
    input  logic [15:0] cfg_div,
    output logic        init_done,
    output logic [3:0]  addr,
    output logic        re,
    output logic        we,
    output logic [31:0] wd,
    input  logic [31:0] rd
);

    seq_state_t  state_r;
    seq_state_t  state_nxt_s;
    logic [15:0] div_r;
    logic [15:0] div_nxt_s;
    logic        reload_pend_r;
    logic        reload_pend_nxt_s;
    logic        last_rx_r;
    logic        reload_hit_s;

    logic [3:0]  addr_nxt_s;
    logic        re_nxt_s;
    logic        we_nxt_s;
    logic [31:0] wd_nxt_s;
    logic        tx_ready_nxt_s;
    logic        rx_valid_nxt_s;
    logic        init_done_nxt_s;

    // Only rd[7:0] (RX byte) and rd[2] (tx_full) carry information here
    logic        unused_rd_s;
    assign unused_rd_s = ^rd[31:8];

    // A reload pulse is honoured in every state except the reset state
    assign reload_hit_s = cfg_reload && (state_r != S_RST);

    // Next-state logic and host arbitration
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_RST:     state_nxt_s = S_INIT_DR;
            S_INIT_DR: state_nxt_s = S_INIT_CR;
            S_INIT_CR: state_nxt_s = S_IDLE;
            S_IDLE: begin
                if (reload_pend_r) begin
                    state_nxt_s = S_INIT_DR;
                end else if (rx_req && tx_valid) begin
                    // Alternate so neither stream can starve the other
                    state_nxt_s = last_rx_r ? S_POLL : S_RD_RX;
                end else if (rx_req) begin
                    state_nxt_s = S_RD_RX;
                end else if (tx_valid) begin
                    state_nxt_s = S_POLL;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_POLL: begin
                // rd reflects the control register because addr is UART_CR
                if (rd[CR_TX_FULL]) begin
                    state_nxt_s = S_POLL;
                end else begin
                    state_nxt_s = S_WR_TX;
                end
            end
            S_WR_TX:   state_nxt_s = S_IDLE;
            S_RD_RX:   state_nxt_s = S_RX_DONE;
            S_RX_DONE: state_nxt_s = S_IDLE;
            default:   state_nxt_s = S_RST;
        endcase
    end

    // Divider and pending-reload bookkeeping
    always_comb begin
        div_nxt_s         = div_r;
        reload_pend_nxt_s = reload_pend_r;
        if (reload_hit_s) begin
            // A newer pulse overrides any older pending value
            div_nxt_s         = cfg_div;
            reload_pend_nxt_s = 1'b1;
        end else if (state_nxt_s == S_INIT_DR) begin
            reload_pend_nxt_s = 1'b0;
        end else begin
            reload_pend_nxt_s = reload_pend_r;
        end
    end

    // Output decode of the state being entered
    always_comb begin
        addr_nxt_s      = 4'h0;
        re_nxt_s        = 1'b0;
        we_nxt_s        = 1'b0;
        wd_nxt_s        = 32'h0000_0000;
        tx_ready_nxt_s  = 1'b0;
        rx_valid_nxt_s  = 1'b0;
        init_done_nxt_s = 1'b0;
        case (state_nxt_s)
            S_RST: begin
                addr_nxt_s = 4'h0;
            end
            S_INIT_DR: begin
                we_nxt_s   = 1'b1;
                addr_nxt_s = UART_DR;
                wd_nxt_s   = {16'h0000, div_nxt_s};
            end
            S_INIT_CR: begin
                we_nxt_s   = 1'b1;
                addr_nxt_s = UART_CR;
                wd_nxt_s   = cr_word(RX_LVL, TX_LVL);
            end
            S_IDLE, S_POLL: begin
                addr_nxt_s      = UART_CR;
                init_done_nxt_s = 1'b1;
            end
            S_WR_TX: begin
                we_nxt_s        = 1'b1;
                addr_nxt_s      = UART_TX_RX;
                wd_nxt_s        = {24'h000000, tx_data};
                tx_ready_nxt_s  = 1'b1;
                init_done_nxt_s = 1'b1;
            end
            S_RD_RX: begin
                re_nxt_s        = 1'b1;
                addr_nxt_s      = UART_TX_RX;
                init_done_nxt_s = 1'b1;
            end
            S_RX_DONE: begin
                rx_valid_nxt_s  = 1'b1;
                init_done_nxt_s = 1'b1;
            end
            default: begin
                addr_nxt_s = 4'h0;
            end
        endcase
    end

    // State, bookkeeping and registered outputs
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_r       <= S_RST;
            div_r         <= DIV;
            reload_pend_r <= 1'b0;
            last_rx_r     <= 1'b0;
            rx_data       <= 8'h00;
            addr          <= 4'h0;
            re            <= 1'b0;
            we            <= 1'b0;
            wd            <= 32'h0000_0000;
            tx_ready      <= 1'b0;
            rx_valid      <= 1'b0;
            init_done     <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            div_r         <= div_nxt_s;
            reload_pend_r <= reload_pend_nxt_s;
            if (state_r == S_WR_TX) begin
                last_rx_r <= 1'b0;
            end else if (state_r == S_RD_RX) begin
                last_rx_r <= 1'b1;
            end else begin
                last_rx_r <= last_rx_r;
            end
            // re pops the FIFO this cycle; capture the head it exposes
            if (state_r == S_RD_RX) begin
                rx_data <= rd[7:0];
            end else begin
                rx_data <= rx_data;
            end
            addr      <= addr_nxt_s;
            re        <= re_nxt_s;
            we        <= we_nxt_s;
            wd        <= wd_nxt_s;
            tx_ready  <= tx_ready_nxt_s;
            rx_valid  <= rx_valid_nxt_s;
            init_done <= init_done_nxt_s;
        end
    end

endmodule

// File: tb/tb_uart_si_seq.sv
// ---------------------------------------------------------------------------
// tb_uart_si_seq
// Self-checking bench for uart_si_seq. A small UART model answers rd from
// addr (control register with a controllable tx_full bit, RX FIFO head from a
// byte table). Expected TX writes and RX bytes are queued when the host side
// drives them and compared by a monitor when the DUT produces them.
// ---------------------------------------------------------------------------
module tb_uart_si_seq;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        tx_valid = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_ready;
    logic        rx_req = 1'b0;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        cfg_reload = 1'b0;
    logic [15:0] cfg_div = 16'h0000;
    logic        init_done;
    logic [3:0]  addr;
    logic        re;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;

    // UART model state
    logic        tx_full = 1'b0;
    logic [7:0]  rx_src [16];
    int          rd_ptr = 0;
    int          rx_idx = 0;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_tx_q [$];
    logic [31:0] exp_rx_q [$];
    bit          grant_q  [$];   // 1 = TX write, 0 = RX read

    localparam logic [31:0] CR_INIT = 32'h0000_0003;

    uart_si_seq dut (
        .clk        (clk),
        .rstn       (rstn),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .rx_req     (rx_req),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .cfg_reload (cfg_reload),
        .cfg_div    (cfg_div),
        .init_done  (init_done),
        .addr       (addr),
        .re         (re),
        .we         (we),
        .wd         (wd),
        .rd         (rd)
    );

    always #5 clk = ~clk;

    // UART read data: combinational in addr
    always_comb begin
        rd = 32'h0000_0000;
        if (addr == 4'h0) begin
            rd[2] = tx_full;
        end else if (addr == 4'h4) begin
            rd[7:0] = rx_src[rd_ptr % 16];
        end else begin
            rd = 32'h0000_0000;
        end
    end

    // RX FIFO pop after the DUT has sampled the head
    always @(posedge clk) begin
        if (re) rd_ptr <= rd_ptr + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rstn) begin
            if (we && addr == 4'h4) begin
                grant_q.push_back(1'b1);
                check_val("tx_ready_with_write", tx_ready, 1);
                check_val("tx_write_expected", exp_tx_q.size() > 0, 1);
                if (exp_tx_q.size() > 0) check_val("tx_wd", wd, exp_tx_q.pop_front());
            end
            if (tx_ready && !(we && addr == 4'h4)) check_val("tx_ready_without_write", tx_ready, 0);
            if (re) begin
                grant_q.push_back(1'b0);
                check_val("re_addr", addr, 4);
                check_val("re_no_we", we, 0);
            end
            if (rx_valid) begin
                check_val("rx_valid_expected", exp_rx_q.size() > 0, 1);
                if (exp_rx_q.size() > 0) check_val("rx_data", rx_data, exp_rx_q.pop_front());
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ctl"}, {re, we, tx_ready, rx_valid, init_done, addr}, 0);
        check_val({tag, "_wd"}, wd, 0);
    endtask

    task automatic reset_and_init(input logic [15:0] exp_div);
        rstn = 1'b1;
        repeat (3) tick();
        check_all_zero("rst_out");
        check_val("rst_rx_data", rx_data, 0);
        rstn = 1'b0;
        tick();
        check_val("init_dr_ctl", {we, re, init_done, addr}, {1'b1, 1'b0, 1'b0, 4'h8});
        check_val("init_dr_wd", wd, {16'h0000, exp_div});
        tick();
        check_val("init_cr_ctl", {we, re, init_done, addr}, {1'b1, 1'b0, 1'b0, 4'h0});
        check_val("init_cr_wd", wd, CR_INIT);
        tick();
        check_val("init_done_idle", {init_done, we, re}, {1'b1, 1'b0, 1'b0});
    endtask

    task automatic push_rx();
        exp_rx_q.push_back({24'h0, rx_src[rx_idx % 16]});
        rx_idx++;
    endtask

    initial begin
        int tx_sent;
        int rx_got;
        bit seen;
        for (int i = 0; i < 16; i++) rx_src[i] = {i[3:0], ~i[3:0]};
        rx_src[0] = 8'hA5;

        // Reset and initial programming with the default divider
        reset_and_init(16'd434);

        // Single TX byte, UART not full
        tx_data = 8'h55; tx_valid = 1'b1; exp_tx_q.push_back(32'h55);
        tick();
        check_val("tx1_poll", {we, tx_ready, init_done, addr}, {1'b0, 1'b0, 1'b1, 4'h0});
        tick();
        check_val("tx1_write", {we, tx_ready, addr}, {1'b1, 1'b1, 4'h4});
        check_val("tx1_wd", wd, 32'h55);
        tx_valid = 1'b0;
        tick();
        check_val("tx1_single", {we, tx_ready}, 0);

        // TX held off by tx_full
        tx_full = 1'b1; tx_data = 8'hC3; tx_valid = 1'b1; exp_tx_q.push_back(32'hC3);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_val("poll_hold", {we, tx_ready, addr}, {1'b0, 1'b0, 4'h0});
        end
        tx_full = 1'b0;
        tick();
        check_val("poll_release_write", {we, tx_ready, addr}, {1'b1, 1'b1, 4'h4});
        check_val("poll_release_wd", wd, 32'hC3);
        tx_valid = 1'b0;
        tick();

        // Single RX request
        rx_req = 1'b1; push_rx();
        tick();
        check_val("rx1_read", {re, addr}, {1'b1, 4'h4});
        tick();
        check_val("rx1_valid", {rx_valid, re}, {1'b1, 1'b0});
        check_val("rx1_data", rx_data, 8'hA5);
        rx_req = 1'b0;
        tick();
        check_val("rx1_single", {re, rx_valid}, 0);

        // Both streams held: last grant was RX, so TX goes first
        grant_q.delete();
        tx_sent = 0; rx_got = 0;
        tx_data = 8'h10; tx_valid = 1'b1; exp_tx_q.push_back(32'h10);
        rx_req = 1'b1; push_rx();
        for (int c = 0; c < 100 && (tx_sent < 4 || rx_got < 4); c++) begin
            tick();
            if (tx_ready) begin
                tx_sent++;
                if (tx_sent < 4) begin
                    tx_data = 8'h10 + 8'(tx_sent);
                    exp_tx_q.push_back({24'h0, tx_data});
                end else begin
                    tx_valid = 1'b0;
                end
            end
            if (rx_valid) begin
                rx_got++;
                if (rx_got < 4) push_rx();
                else rx_req = 1'b0;
            end
        end
        check_val("alt_tx_count", tx_sent, 4);
        check_val("alt_rx_count", rx_got, 4);
        check_val("alt_grants", grant_q.size(), 8);
        for (int i = 0; i < grant_q.size(); i++)
            check_val($sformatf("alt_order_%0d", i), grant_q[i], (i % 2 == 0) ? 1 : 0);
        tick();

        // Reload arriving during a TX write
        tx_data = 8'h77; tx_valid = 1'b1; exp_tx_q.push_back(32'h77);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            if (tx_ready) seen = 1'b1;
        end
        check_val("reload_tx_ready_seen", seen, 1);
        cfg_reload = 1'b1; cfg_div = 16'd27; tx_valid = 1'b0;
        tick();
        cfg_reload = 1'b0;
        check_val("reload_idle", {init_done, we}, {1'b1, 1'b0});
        tick();
        check_val("reload_dr_ctl", {we, init_done, addr}, {1'b1, 1'b0, 4'h8});
        check_val("reload_dr_wd", wd, 32'd27);
        tick();
        check_val("reload_cr_ctl", {we, init_done, addr}, {1'b1, 1'b0, 4'h0});
        check_val("reload_cr_wd", wd, CR_INIT);
        tick();
        check_val("reload_done", {init_done, we}, {1'b1, 1'b0});

        // Reset in the middle of polling drops the byte
        tx_full = 1'b1; tx_data = 8'h99; tx_valid = 1'b1;
        tick();
        tick();
        check_val("mid_poll_state", {we, init_done, addr}, {1'b0, 1'b1, 4'h0});
        rstn = 1'b1;
        tick();
        check_all_zero("mid_poll_rst");
        tx_valid = 1'b0; tx_full = 1'b0;
        reset_and_init(16'd434);

        check_val("tx_queue_drained", exp_tx_q.size(), 0);
        check_val("rx_queue_drained", exp_rx_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_si_seq.md
Name: uart_si_seq

Overview:
Sequencer that owns the simple interface of the UART peripheral (addr/re/we/wd/rd) and hides register-level access from a byte-stream host.
- After reset it programs the divider and control registers.
- It then arbitrates between a host TX byte stream (valid/ready) and host RX read requests.
- Before each TX data write it polls tx_full in the control register.
- It sits between a simple stream client (e.g. debug/console logic) and the UART top.

Parameters:
DIV, 16'd434, divider value written to the UART divider register at init
TX_LVL, 2'b00, TX FIFO level field written into control register bits [5:4]
RX_LVL, 2'b00, RX FIFO level field written into control register bits [7:6]

Ports:
clk  input  1  clock
rstn  input  1  reset; synchronous, active-high (rstn=1 resets the block)
tx_valid  input  1  host has a TX byte; tx_data must be held stable while tx_valid=1
tx_data  input  8  TX byte
tx_ready  output  1  one-cycle pulse; byte accepted (written to UART) this cycle
rx_req  input  1  host requests one RX FIFO read; level, held until rx_valid
rx_valid  output  1  one-cycle pulse; rx_data valid
rx_data  output  8  byte read from RX FIFO, registered
cfg_reload  input  1  pulse; reprogram divider with cfg_div and redo init
cfg_div  input  16  new divider value, sampled together with cfg_reload
init_done  output  1  high while in IDLE/service states after a completed init
addr  output  4  UART SI address
re  output  1  UART SI read enable (pops RX FIFO)
we  output  1  UART SI write enable
wd  output  32  UART SI write data
rd  input  32  UART SI read data (combinational in addr on the UART side)

Behaviour:
- All outputs are Moore-decoded from state, except rx_data (register).
- Reset: state=S_RST, div_r=DIV, reload_pend=0, last_rx=0, rx_data=0. All outputs 0 while in S_RST: addr, re, we, wd, tx_ready, rx_valid, init_done.
- Reset asserted in any state returns to S_RST on the next edge. An in-flight transfer is dropped: no tx_ready, no rx_valid.
- States:
  - S_RST -> S_INIT_DR unconditionally.
  - S_INIT_DR: we=1, addr=8, wd={16'0,div_r}. Next state S_INIT_CR.
  - S_INIT_CR: we=1, addr=0, wd={24'0,RX_LVL,TX_LVL,2'b00,2'b11}. Enables TX and RX. Next state S_IDLE.
  - S_IDLE: addr=0, init_done=1. Priority:
    1. reload_pend -> S_INIT_DR.
    2. Both rx_req and tx_valid pending: RX if last_rx=0, else TX (alternating).
    3. Only rx_req -> S_RD_RX.
    4. Only tx_valid -> S_POLL.
  - S_POLL: addr=0, re=0, we=0, init_done=1. Sample rd[2] (tx_full) at the edge: 0 -> S_WR_TX, 1 -> stay in S_POLL. There is no timeout.
  - S_WR_TX: we=1, addr=4, wd={24'0,tx_data}, tx_ready=1. Set last_rx=0. Next state S_IDLE.
  - S_RD_RX: re=1, addr=4. rx_data<=rd[7:0] at the edge. Set last_rx=1. Next state S_RX_DONE.
  - S_RX_DONE: rx_valid=1. Next state S_IDLE.
- cfg_reload in any non-reset state sets reload_pend and loads div_r<=cfg_div (a later pulse overwrites).
  - Serviced at the next S_IDLE; the current transfer completes first.
  - reload_pend clears on entry to S_INIT_DR.
  - init_done=0 in S_INIT_DR and S_INIT_CR.
- Throughput:
  - TX: 3 cycles per byte minimum (IDLE, POLL, WR_TX).
  - RX: 3 cycles per byte minimum (IDLE, RD_RX, RX_DONE).
- RX FIFO emptiness is not visible through the SI. rx_req on an empty FIFO returns the FIFO head value unchanged; host protocol is responsible for avoiding this.
- rd bits other than [2] and [7:0] are ignored.

Decomposition:
- Package uart_si_pkg:
  - address constants UART_CR=4'h0, UART_TX_RX=4'h4, UART_DR=4'h8;
  - CR bit positions (TX_EN=0, RX_EN=1, TX_FULL=2, RX_FULL=3, TX_LVL=5:4, RX_LVL=7:6);
  - state enum seq_state_t.
- No new sub-module. div_r uses the existing reg_we with a reset value override, or is inline.

Test Plan:
- Release reset -> cycle 1: we=1, addr=8, wd=0x1B2; cycle 2: we=1, addr=0, wd=0x03; cycle 3: init_done=1, no SI enables.
- After init, tx_valid=1, tx_data=0x55, rd[2]=0 -> one S_POLL cycle (addr=0, we=0); next cycle we=1, addr=4, wd=0x55, tx_ready=1; exactly one write.
- tx_full (rd[2]) held 1 for 5 cycles -> 5+ POLL cycles, no we, tx_ready=0; write of held byte occurs the cycle after rd[2] drops.
- rx_req=1, UART rd[7:0]=0xA5 at addr 4 -> one cycle re=1/addr=4; next cycle rx_valid=1, rx_data=0xA5; re never asserted twice per request.
- rx_req and tx_valid held high continuously -> grants alternate RX, TX, RX, TX. Check re/we pulses interleave and no pulse is lost.
- cfg_reload with cfg_div=16'd27 during S_WR_TX -> the write completes with tx_ready=1, then DR write wd=27, then CR write, init_done=0 for 2 cycles. Assert rstn mid-S_POLL -> next cycle all outputs 0 and no tx_ready.
